// File: rtl/part_buf_pkg.sv
// Shared constants and helpers for the partition-buffer FIFO controller.
package part_buf_pkg;

  localparam int unsigned DefDataWidth   = 64;
  localparam int unsigned DefAddrWidth   = 3;
  localparam int unsigned DefAfullThresh = 6;

  // Default-width pointer and occupancy types; count is one bit wider than the pointer
  // so that full and empty are distinguishable.
  typedef logic [DefAddrWidth-1:0] ptr_t;
  typedef logic [DefAddrWidth:0]   cnt_t;

  // Number of BRAM entries addressed by an aw-bit pointer.
  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/part_buf_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around an external partition-buffer BRAM with a
// 1-cycle registered read port. Optional high-water-mark output: define PART_BUF_HWM_EN.
module part_buf_fifo_ctrl
  import part_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned AFULL_THRESH = DefAfullThresh
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  afull_o,
  output logic [ADDR_WIDTH-1:0] bram_waddr_o,
  output logic                  bram_we_o,
  output logic [DATA_WIDTH-1:0] bram_wdata_o,
  output logic [ADDR_WIDTH-1:0] bram_raddr_o,
  output logic                  bram_rd_en_o,
  input  logic [DATA_WIDTH-1:0] bram_out_i
`ifdef PART_BUF_HWM_EN
  ,
  output logic [ADDR_WIDTH:0]   hwm_o
`endif
);

  typedef logic [ADDR_WIDTH-1:0] ptr_w_t;
  typedef logic [ADDR_WIDTH:0]   cnt_w_t;

  localparam cnt_w_t DepthCnt = cnt_w_t'(depth(ADDR_WIDTH));
  localparam cnt_w_t AfullCnt = cnt_w_t'(AFULL_THRESH);

  ptr_w_t wptr_q, wptr_d;
  ptr_w_t rptr_q, rptr_d;
  cnt_w_t count_q, count_d;
  logic   out_valid_q, out_valid_d;
  logic   afull_q, afull_d;
  logic   full, push, adv, pop, clr;
`ifdef PART_BUF_HWM_EN
  cnt_w_t hwm_q, hwm_d;
`endif

  // Handshake, pointer/count next-state and BRAM port drive.
  always_comb begin
    clr  = rst_i | flush_i;
    full = (count_q == DepthCnt);
    // in_ready looks only at registered count so a same-cycle pop never frees the write port.
    in_ready_o = ~full;
    push = in_valid_i & ~full & ~clr;
    adv  = ~out_valid_q | out_ready_i;
    // Uses pre-push count, so the slot being written this cycle is never read.
    pop  = adv & (count_q != '0);

    wptr_d = push ? wptr_q + ptr_w_t'(1) : wptr_q;
    rptr_d = pop ? rptr_q + ptr_w_t'(1) : rptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_t'(1);
      2'b01:   count_d = count_q - cnt_w_t'(1);
      default: count_d = count_q;
    endcase

    out_valid_d = out_valid_q;
    if (pop) begin
      out_valid_d = 1'b1;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end

    afull_d = (count_d >= AfullCnt);
`ifdef PART_BUF_HWM_EN
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
`endif

    bram_we_o    = push;
    bram_waddr_o = wptr_q;
    bram_wdata_o = in_data_i;
    bram_raddr_o = rptr_q;
    bram_rd_en_o = adv;
    out_data_o   = bram_out_i;
    out_valid_o  = out_valid_q;
    count_o      = count_q;
    afull_o      = afull_q;
  end

  // State register; rst and flush clear everything identically.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
    end
  end

`ifdef PART_BUF_HWM_EN
  // Peak occupancy since the last reset or flush.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm_o = hwm_q;
`endif

endmodule

// File: doc/part_buf_fifo_ctrl.md
Name: part_buf_fifo_ctrl

Overview:
Pointer/flow-control wrapper that sits directly around the partition buffer BRAM (1-cycle read latency, output register held while its enable is low). It turns the raw write/read ports into a valid/ready FIFO. The upstream side is the partitioner tuple stream; the downstream side is the flush/write-out stage. The BRAM stays external: this block drives its waddr/we/data/raddr/enable and uses its registered out directly as out_data.

Parameters:
DATA_WIDTH, 64, tuple width; must match the BRAM.
ADDR_WIDTH, 3, BRAM address width; DEPTH = 2**ADDR_WIDTH.
AFULL_THRESH, 6, occupancy at or above which afull asserts; legal range 1..DEPTH.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of contents; same effect as rst on state.
in_valid  in  1  upstream tuple valid.
in_ready  out  1  space available.
in_data  in  DATA_WIDTH  upstream tuple.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_WIDTH  wired from bram_out.
count  out  ADDR_WIDTH+1  entries in BRAM, excluding the one in the output register.
afull  out  1  count >= AFULL_THRESH.
bram_waddr  out  ADDR_WIDTH  to BRAM waddr.
bram_we  out  1  to BRAM we.
bram_wdata  out  DATA_WIDTH  to BRAM data.
bram_raddr  out  ADDR_WIDTH  to BRAM raddr.
bram_rd_en  out  1  to BRAM out_ready (output register enable).
bram_out  in  DATA_WIDTH  from BRAM out.

Behaviour:
- Reset or flush (rst has priority): wptr=0, rptr=0, count=0, out_valid=0, afull=0. in_ready is 1 in the cycle after reset deasserts. A push presented in a flush cycle is dropped. bram_out content after flush is don't-care.
- Full status: full = (count == DEPTH). in_ready = !full, derived combinationally from registered count only; never from out_ready.
- Push: push = in_valid & in_ready. bram_we = push, bram_waddr = wptr, bram_wdata = in_data. wptr increments mod DEPTH.
- Advance: adv = !out_valid | out_ready. bram_rd_en = adv.
- Pop: pop = adv & (count != 0). bram_raddr = rptr. On pop, rptr increments mod DEPTH and out_valid<=1 next cycle. On adv & count==0, out_valid<=0.
- Hold: with !adv, out_valid and bram_out (via the BRAM's hold) are stable.
- Latency: a tuple written into an empty FIFO at cycle t is visible at out_valid/out_data at t+2. A write at t commits count at t+1, read is issued at t+1, data is registered at t+2.
- Read-after-write safety: pop decisions use count from before this cycle's push, so the slot being written is never read in the same cycle.
- Occupancy: count_next = count + push - pop. Simultaneous push and pop leaves count unchanged. At full, in_ready=0 even if a pop occurs that cycle, so the write port is not freed combinationally.
- Total capacity is DEPTH + 1: DEPTH entries in the BRAM plus 1 in the BRAM output register.
- Pointers wrap naturally at ADDR_WIDTH bits. count is 1 bit wider to distinguish full from empty.
- afull is registered from count_next.

Optional Feature:
Macro PART_BUF_HWM_EN.
- Defined: adds output hwm [ADDR_WIDTH:0], the maximum count seen since reset/flush; updated as max(hwm, count_next) each cycle; cleared by rst and flush.
- Undefined: port and register absent; no other behaviour changes.

Decomposition:
- Package part_buf_pkg: function for DEPTH from ADDR_WIDTH, ptr_t/cnt_t typedef widths, and the default AFULL_THRESH constant.
- No sub-module needed. Pointer/count logic is one always_ff plus combinational handshake.
- The bench instantiates the BRAM alongside this block.

Test Plan:
- Reset then push 0xA1 with out_ready=1 held -> out_valid rises exactly 2 cycles after the push cycle with out_data=0xA1; count returns to 0.
- Push 8 tuples (ADDR_WIDTH=3) with out_ready=0 -> first tuple sits in the output register, count reaches 7, then push 2 more -> count=8, in_ready=0; afull asserted from count>=6; extra push attempts are ignored.
- From full, out_ready=1 for 9 cycles -> 9 tuples emerge in order, with no bubble after the first; count=0 and out_valid drops after the last.
- Continuous push and pop with out_ready toggling 1,0,1,0 over 20 tuples 0..19 -> in-order, no loss or duplication; out_data stable whenever out_valid & !out_ready; pointers wrap past 7.
- Fill to count=5 and assert flush for 1 cycle with in_valid=1 -> next cycle count=0, out_valid=0, the flushed push is lost, and hwm=0 when PART_BUF_HWM_EN is defined.
- Assert rst mid-stream with out_valid=1 -> next cycle out_valid=0, count=0, in_ready=1; a subsequent push of 0x5 is delivered as the first output.
